instruction_fetch_unit: RTL and testbench

- Sits directly downstream of the 8-bit program counter.
- Takes the current PC, issues a read to instruction memory using a req/ack handshake, and buffers returned instructions together with their PC in a 2-entry FIFO.
- Presents the buffered instructions to the decoder via valid/ready.
- Drives the PC count-enable and flushes the FIFO on jumps, where a jump is the PC load-enable cycle.

---
 rtl/instruction_fetch_unit.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues req/ack reads at the current PC, buffers
// {instruction, pc} pairs in a 2-entry FIFO and steps the PC once per fetch.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    input  logic                   i_jump_en,
    output logic                   o_pc_counter_en,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    input  logic                   i_instr_ready
);

    typedef enum logic [1:0] {IDLE, REQ, INCR, SETTLE} state_t;

    state_t                 state;
    logic [1:0]             count;
    logic [INSTR_WIDTH-1:0] tail_instr;
    logic [ADDR_WIDTH-1:0]  tail_pc;
    logic                   push;
    logic                   pop;

    // A jump overrides both FIFO ports so a flush never races a push or pop.
    assign push            = (state == REQ) & i_imem_ack & ~i_jump_en;
    assign pop             = o_instr_valid & i_instr_ready & ~i_jump_en;
    assign o_instr_valid   = (count != 2'd0);
    assign o_pc_counter_en = (state == INCR) & ~i_jump_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            o_imem_req  <= 1'b0;
            o_imem_addr <= '0;
        end else begin
            case (state)
                IDLE, SETTLE: begin
                    if (i_jump_en) begin
                        state <= SETTLE;
                    end else if (count <= 2'd1) begin
                        state       <= REQ;
                        o_imem_req  <= 1'b1;
                        o_imem_addr <= i_pc;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // Dropping req without an ack abandons the read.
                    if (i_jump_en) begin
                        state      <= SETTLE;
                        o_imem_req <= 1'b0;
                    end else if (i_imem_ack) begin
                        state      <= INCR;
                        o_imem_req <= 1'b0;
                    end
                end
                INCR: begin
                    state <= SETTLE;
                end
                default: begin
                    state      <= IDLE;
                    o_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Head entry lives directly in the output registers; zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            o_instr    <= '0;
            o_instr_pc <= '0;
        end else if (i_jump_en) begin
            count      <= 2'd0;
            o_instr    <= '0;
            o_instr_pc <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    if (count == 2'd0) begin
                        o_instr    <= i_imem_data;
                        o_instr_pc <= o_imem_addr;
                    end
                end
                2'b01: begin
                    count <= count - 2'd1;
                    if (count == 2'd2) begin
                        o_instr    <= tail_instr;
                        o_instr_pc <= tail_pc;
                    end else begin
                        o_instr    <= '0;
                        o_instr_pc <= '0;
                    end
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        o_instr    <= i_imem_data;
                        o_instr_pc <= o_imem_addr;
                    end else begin
                        o_instr    <= tail_instr;
                        o_instr_pc <= tail_pc;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

    // Tail is pure data; it is only read while count says it is occupied.
    always_ff @(posedge clk) begin
        if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) begin
            tail_instr <= i_imem_data;
            tail_pc    <= o_imem_addr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-by-cycle vectors for instruction_fetch_unit plus an
// asynchronous-reset-during-request sequence.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_pc;
    logic        i_jump_en;
    logic        o_pc_counter_en;
    logic        o_imem_req;
    logic [7:0]  o_imem_addr;
    logic        i_imem_ack;
    logic [15:0] i_imem_data;
    logic        o_instr_valid;
    logic [15:0] o_instr;
    logic [7:0]  o_instr_pc;
    logic        i_instr_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pc            (i_pc),
        .i_jump_en       (i_jump_en),
        .o_pc_counter_en (o_pc_counter_en),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_ack      (i_imem_ack),
        .i_imem_data     (i_imem_data),
        .o_instr_valid   (o_instr_valid),
        .o_instr         (o_instr),
        .o_instr_pc      (o_instr_pc),
        .i_instr_ready   (i_instr_ready)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  pc;
        logic        jmp;
        logic        ack;
        logic [15:0] data;
        logic        rdy;
        logic        ereq;
        logic [7:0]  eaddr;
        logic        ecen;
        logic        evld;
        logic [15:0] einstr;
        logic [7:0]  eipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] pc, input logic jmp,
                       input logic ack, input logic [15:0] data, input logic rdy,
                       input logic ereq, input logic [7:0] eaddr, input logic ecen,
                       input logic evld, input logic [15:0] einstr, input logic [7:0] eipc);
        vec_t v;
        v = '{r, pc, jmp, ack, data, rdy, ereq, eaddr, ecen, evld, einstr, eipc};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        i_pc          = 8'h00;
        i_jump_en     = 1'b0;
        i_imem_ack    = 1'b0;
        i_imem_data   = 16'h0000;
        i_instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive(input logic [7:0] pc, input logic jmp, input logic ack,
                         input logic [15:0] data, input logic rdy);
        @(negedge clk);
        i_pc          = pc;
        i_jump_en     = jmp;
        i_imem_ack    = ack;
        i_imem_data   = data;
        i_instr_ready = rdy;
        #1;
    endtask

    initial begin
        // Sequential fetch, decoder always ready, ack in the same cycle.
        add(1,8'h00,0,1,16'hA000,1, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,1, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hDEAD,1, 0,8'h00,1,1,16'hA000,8'h00);
        add(0,8'h01,0,1,16'hDEAD,1, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h01,0,1,16'hA001,1, 1,8'h01,0,0,16'h0000,8'h00);
        add(0,8'h01,0,1,16'hDEAD,1, 0,8'h01,1,1,16'hA001,8'h01);
        add(0,8'h02,0,1,16'hDEAD,1, 0,8'h01,0,0,16'h0000,8'h00);
        add(0,8'h02,0,1,16'hA002,1, 1,8'h02,0,0,16'h0000,8'h00);
        add(0,8'h02,0,1,16'hDEAD,1, 0,8'h02,1,1,16'hA002,8'h02);
        // Decoder stalled: FIFO fills to two, fetching halts, resumes after a pop.
        add(1,8'h00,0,1,16'hA000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,0, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hDEAD,0, 0,8'h00,1,1,16'hA000,8'h00);
        add(0,8'h01,0,1,16'hDEAD,0, 0,8'h00,0,1,16'hA000,8'h00);
        add(0,8'h01,0,1,16'hA001,0, 1,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h01,0,1,16'hDEAD,0, 0,8'h01,1,1,16'hA000,8'h00);
        add(0,8'h02,0,1,16'hDEAD,0, 0,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h02,0,1,16'hDEAD,0, 0,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h02,0,1,16'hDEAD,1, 0,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h02,0,1,16'hDEAD,0, 0,8'h01,0,1,16'hA001,8'h01);
        add(0,8'h02,0,1,16'hA002,0, 1,8'h02,0,1,16'hA001,8'h01);
        add(0,8'h02,0,0,16'h0000,1, 0,8'h02,1,1,16'hA001,8'h01);
        add(0,8'h03,0,0,16'h0000,1, 0,8'h02,0,1,16'hA002,8'h02);
        add(0,8'h03,0,0,16'h0000,1, 1,8'h03,0,0,16'h0000,8'h00);
        // Slow memory, jump to 0x40 in the second wait cycle with a racing ack.
        add(1,8'h00,0,1,16'hA000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,0, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,0,16'h0000,0, 0,8'h00,1,1,16'hA000,8'h00);
        add(0,8'h01,0,0,16'h0000,0, 0,8'h00,0,1,16'hA000,8'h00);
        add(0,8'h01,0,0,16'h0000,0, 1,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h01,1,1,16'hBAD1,1, 1,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h40,0,1,16'hBAD2,0, 0,8'h01,0,0,16'h0000,8'h00);
        add(0,8'h40,0,0,16'h0000,0, 1,8'h40,0,0,16'h0000,8'h00);
        add(0,8'h40,0,1,16'hA040,0, 1,8'h40,0,0,16'h0000,8'h00);
        add(0,8'h40,0,0,16'h0000,0, 0,8'h40,1,1,16'hA040,8'h40);
        // Jump in INCR suppresses the increment; a second jump in SETTLE restarts it.
        add(1,8'h00,0,0,16'h0000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,0, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,1,0,16'h0000,0, 0,8'h00,0,1,16'hA000,8'h00);
        add(0,8'h80,1,0,16'h0000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'hC0,0,0,16'h0000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'hC0,0,1,16'hA0C0,0, 1,8'hC0,0,0,16'h0000,8'h00);
        add(0,8'hC0,0,0,16'h0000,0, 0,8'hC0,1,1,16'hA0C0,8'hC0);
        // Push and pop together at count one: head advances with no valid gap.
        add(1,8'h00,0,0,16'h0000,0, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,0, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,0,16'h0000,0, 0,8'h00,1,1,16'hA000,8'h00);
        add(0,8'h01,0,0,16'h0000,0, 0,8'h00,0,1,16'hA000,8'h00);
        add(0,8'h01,0,1,16'hA001,1, 1,8'h01,0,1,16'hA000,8'h00);
        add(0,8'h01,0,0,16'h0000,0, 0,8'h01,1,1,16'hA001,8'h01);
        add(0,8'h02,0,0,16'h0000,0, 0,8'h01,0,1,16'hA001,8'h01);
        add(0,8'h02,0,0,16'h0000,0, 1,8'h02,0,1,16'hA001,8'h01);
        // PC wrap from 0xFF to 0x00 passes through unchanged.
        add(1,8'hFF,0,1,16'hA0FF,1, 0,8'h00,0,0,16'h0000,8'h00);
        add(0,8'hFF,0,1,16'hA0FF,1, 1,8'hFF,0,0,16'h0000,8'h00);
        add(0,8'hFF,0,0,16'h0000,1, 0,8'hFF,1,1,16'hA0FF,8'hFF);
        add(0,8'h00,0,0,16'h0000,1, 0,8'hFF,0,0,16'h0000,8'h00);
        add(0,8'h00,0,1,16'hA000,1, 1,8'h00,0,0,16'h0000,8'h00);
        add(0,8'h00,0,0,16'h0000,1, 0,8'h00,1,1,16'hA000,8'h00);

        rst_n = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].pc, vecs[i].jmp, vecs[i].ack, vecs[i].data, vecs[i].rdy);
            chk($sformatf("v%0d req", i),   32'(o_imem_req),      32'(vecs[i].ereq));
            chk($sformatf("v%0d addr", i),  32'(o_imem_addr),     32'(vecs[i].eaddr));
            chk($sformatf("v%0d cen", i),   32'(o_pc_counter_en), 32'(vecs[i].ecen));
            chk($sformatf("v%0d vld", i),   32'(o_instr_valid),   32'(vecs[i].evld));
            chk($sformatf("v%0d instr", i), 32'(o_instr),         32'(vecs[i].einstr));
            chk($sformatf("v%0d ipc", i),   32'(o_instr_pc),      32'(vecs[i].eipc));
        end

        // Asynchronous reset while a request is outstanding with one entry buffered.
        do_reset();
        drive(8'h33, 1'b0, 1'b1, 16'hA033, 1'b0);
        drive(8'h33, 1'b0, 1'b1, 16'hA033, 1'b0);
        drive(8'h33, 1'b0, 1'b0, 16'h0000, 1'b0);
        drive(8'h34, 1'b0, 1'b0, 16'h0000, 1'b0);
        drive(8'h34, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("pre_rst req",   32'(o_imem_req),    32'd1);
        chk("pre_rst addr",  32'(o_imem_addr),   32'h34);
        chk("pre_rst vld",   32'(o_instr_valid), 32'd1);
        chk("pre_rst instr", 32'(o_instr),       32'hA033);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst req",   32'(o_imem_req),      32'd0);
        chk("async_rst addr",  32'(o_imem_addr),     32'd0);
        chk("async_rst cen",   32'(o_pc_counter_en), 32'd0);
        chk("async_rst vld",   32'(o_instr_valid),   32'd0);
        chk("async_rst instr", 32'(o_instr),         32'd0);
        chk("async_rst ipc",   32'(o_instr_pc),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
